mem_stage_lsu: RTL and testbench

//  Memory-access pipeline stage: byte-addressed data RAM, sized/signed loads and byte-lane stores, plus a MEM/WB output register.
//  - Sits between the ALU stage and register-file writeback.
//  - Adds programmable memory wait states with a stall handshake to upstream.
//  - Adds optional misalignment detection.

---
 rtl/mem_stage_lsu.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage: byte-addressed data RAM, sized/signed loads, byte-lane stores, MEM/WB register.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] ALU_o,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic [2:0]            funct3,
    input  logic                  ResultSrc,
    input  logic                  MemWrite,
    input  logic [4:0]            rd_i,
    input  logic                  RegWrite_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] Result,
    output logic [4:0]            rd_o,
    output logic                  RegWrite_o,
    output logic                  misalign_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [2:0] CNT_INIT = (MEM_LATENCY > 0) ? 3'(MEM_LATENCY - 1) : 3'd0;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] alu_q;
    logic [DATA_WIDTH-1:0] wd_q;
    logic [2:0]            f3_q;
    logic                  load_q;
    logic                  store_q;
    logic [4:0]            rd_q;
    logic                  regWrite_q;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [4:0]            rdOut_q, rdOut_d;
    logic                  regWriteOut_q, regWriteOut_d;
    logic                  misalign_q, misalign_d;
    logic                  stall_q, stall_d;

    logic [7:0]            mem [DEPTH];

    logic                  inWait;
    logic [DATA_WIDTH-1:0] curAlu;
    logic [DATA_WIDTH-1:0] curWd;
    logic [2:0]            curF3;
    logic                  curLoad;
    logic                  curStore;
    logic                  curMem;
    logic [4:0]            curRd;
    logic                  curRegWrite;

    logic                  doneNow;
    logic                  accessNow;
    logic [1:0]            accSize;
    logic [ADDR_WIDTH-1:0] byteAddr;
    logic [ADDR_WIDTH-1:0] lowMask;
    logic [ADDR_WIDTH-1:0] baseAddr;
    logic                  trapped;
    logic [DATA_WIDTH-1:0] rawData;
    logic [DATA_WIDTH-1:0] loadData;
    logic [NB-1:0]         laneEn;
    logic                  memWe;

    // In WAIT the latched request drives the datapath; in IDLE the live inputs do,
    // which lets a zero-latency access and a pass-through op complete at the accept edge.
    assign inWait      = (state_q == ST_WAIT);
    assign curAlu      = inWait ? alu_q      : ALU_o;
    assign curWd       = inWait ? wd_q       : WD;
    assign curF3       = inWait ? f3_q       : funct3;
    assign curLoad     = inWait ? load_q     : ResultSrc;
    assign curStore    = inWait ? store_q    : (MemWrite & ~ResultSrc);
    assign curRd       = inWait ? rd_q       : rd_i;
    assign curRegWrite = inWait ? regWrite_q : RegWrite_i;
    assign curMem      = curLoad | curStore;

    always_comb begin
        doneNow = 1'b0;
        if (inWait) begin
            doneNow = (cnt_q == 3'd0);
        end else if (valid_i) begin
            doneNow = !curMem || (MEM_LATENCY == 0);
        end
    end

    assign accessNow = doneNow & curMem;

    // D and WU exist only on 64-bit builds; anything unrecognised becomes a full-width access.
    always_comb begin
        case (curF3)
            3'b000, 3'b100: accSize = 2'd0;
            3'b001, 3'b101: accSize = 2'd1;
            3'b010, 3'b110: accSize = 2'd2;
            default:        accSize = (DATA_WIDTH == 64) ? 2'd3 : 2'd2;
        endcase
    end

    always_comb begin
        case (accSize)
            2'd0:    lowMask = ADDR_WIDTH'(0);
            2'd1:    lowMask = ADDR_WIDTH'(1);
            2'd2:    lowMask = ADDR_WIDTH'(3);
            default: lowMask = ADDR_WIDTH'(7);
        endcase
    end

    assign byteAddr = curAlu[ADDR_WIDTH-1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    assign baseAddr = byteAddr;
    assign trapped  = curMem && ((byteAddr & lowMask) != ADDR_WIDTH'(0));
`else
    assign baseAddr = byteAddr & ~lowMask;
    assign trapped  = 1'b0;
`endif

    always_comb begin
        rawData = '0;
        for (int i = 0; i < NB; i++) begin
            rawData[8*i +: 8] = mem[baseAddr + ADDR_WIDTH'(i)];
        end
    end

    always_comb begin
        case (accSize)
            2'd0:    loadData = curF3[2] ? DATA_WIDTH'(rawData[7:0])
                                         : DATA_WIDTH'($signed(rawData[7:0]));
            2'd1:    loadData = curF3[2] ? DATA_WIDTH'(rawData[15:0])
                                         : DATA_WIDTH'($signed(rawData[15:0]));
            2'd2:    loadData = curF3[2] ? DATA_WIDTH'(rawData[31:0])
                                         : DATA_WIDTH'($signed(rawData[31:0]));
            default: loadData = rawData;
        endcase
    end

    always_comb begin
        laneEn = '0;
        for (int i = 0; i < NB; i++) begin
            laneEn[i] = (i < (1 << accSize));
        end
    end

    // Gating with rst_n keeps a store from landing while reset is held.
    assign memWe = rst_n & accessNow & curStore & ~trapped;

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < NB; i++) begin
                if (laneEn[i]) begin
                    mem[baseAddr + ADDR_WIDTH'(i)] <= curWd[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_d       = 1'b0;
        valid_d       = 1'b0;
        result_d      = result_q;
        rdOut_d       = rdOut_q;
        regWriteOut_d = 1'b0;
        misalign_d    = 1'b0;

        if (!inWait) begin
            if (valid_i && curMem && (MEM_LATENCY > 0)) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_INIT;
                stall_d = 1'b1;
            end
        end else if (cnt_q == 3'd0) begin
            state_d = ST_IDLE;
        end else begin
            cnt_d   = cnt_q - 3'd1;
            stall_d = 1'b1;
        end

        if (doneNow) begin
            valid_d       = 1'b1;
            rdOut_d       = curRd;
            regWriteOut_d = curRegWrite;
            misalign_d    = trapped;
            if (curLoad) begin
                result_d = trapped ? '0 : loadData;
            end else begin
                result_d = curAlu;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            alu_q         <= '0;
            wd_q          <= '0;
            f3_q          <= 3'd0;
            load_q        <= 1'b0;
            store_q       <= 1'b0;
            rd_q          <= 5'd0;
            regWrite_q    <= 1'b0;
            valid_q       <= 1'b0;
            result_q      <= '0;
            rdOut_q       <= 5'd0;
            regWriteOut_q <= 1'b0;
            misalign_q    <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            result_q      <= result_d;
            rdOut_q       <= rdOut_d;
            regWriteOut_q <= regWriteOut_d;
            misalign_q    <= misalign_d;
            stall_q       <= stall_d;
            if (!inWait && valid_i) begin
                alu_q      <= ALU_o;
                wd_q       <= WD;
                f3_q       <= funct3;
                load_q     <= ResultSrc;
                store_q    <= MemWrite & ~ResultSrc;
                rd_q       <= rd_i;
                regWrite_q <= RegWrite_i;
            end
        end
    end

    assign stall_o    = stall_q;
    assign valid_o    = valid_q;
    assign Result     = result_q;
    assign rd_o       = rdOut_q;
    assign RegWrite_o = regWriteOut_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with three wait states.
// Expected values follow LSU_MISALIGN_TRAP_EN when the build defines it.
module tb_mem_stage_lsu;

    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] aluIn;
    logic [31:0] wdIn;
    logic [2:0]  funct3;
    logic        resultSrc;
    logic        memWrite;
    logic [4:0]  rdIn;
    logic        regWriteIn;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result;
    logic [4:0]  rd_o;
    logic        regWrite_o;
    logic        misalign_o;

    int checkCount = 0;
    int failCount  = 0;

    mem_stage_lsu #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .ALU_o     (aluIn),
        .WD        (wdIn),
        .funct3    (funct3),
        .ResultSrc (resultSrc),
        .MemWrite  (memWrite),
        .rd_i      (rdIn),
        .RegWrite_i(regWriteIn),
        .stall_o   (stall_o),
        .valid_o   (valid_o),
        .Result    (result),
        .rd_o      (rd_o),
        .RegWrite_o(regWrite_o),
        .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic driveRequest(input logic isLoad, input logic isStore, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [4:0] rd, input logic rw);
        valid_i    = 1'b1;
        resultSrc  = isLoad;
        memWrite   = isStore;
        funct3     = f3;
        aluIn      = addr;
        wdIn       = data;
        rdIn       = rd;
        regWriteIn = rw;
    endtask

    // Issues one request and returns the cycle (1 = first cycle after accept) where valid_o rose.
    task automatic applyStimulus(input logic isLoad, input logic isStore, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rd, input logic rw,
                                 output int cycles, output int stalls);
        int guard = 0;
        @(negedge clk);
        while (stall_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        driveRequest(isLoad, isStore, f3, addr, data, rd, rw);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        cycles  = 1;
        stalls  = 0;
        while (!valid_o && cycles < 50) begin
            stalls += int'(stall_o);
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!valid_o) checkOutput("valid_timeout", 32'(valid_o), 32'd1);
    endtask

    task automatic storeOp(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic expMis);
        int cyc, stl;
        applyStimulus(1'b0, 1'b1, f3, addr, data, 5'd3, 1'b1, cyc, stl);
        checkOutput({tag, "_lat"}, 32'(cyc), 32'(1 + LAT));
        checkOutput({tag, "_stall"}, 32'(stl), 32'(LAT));
        checkOutput({tag, "_mis"}, 32'(misalign_o), 32'(expMis));
    endtask

    task automatic loadCheck(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] expected, input logic expMis);
        int cyc, stl;
        applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, 5'd7, 1'b1, cyc, stl);
        checkOutput({tag, "_lat"}, 32'(cyc), 32'(1 + LAT));
        checkOutput(tag, result, expected);
        checkOutput({tag, "_mis"}, 32'(misalign_o), 32'(expMis));
    endtask

    initial begin
        int cyc, stl;
        logic [31:0] expMisLoad, expAfterMisStore;
        logic        trapOn;

`ifdef LSU_MISALIGN_TRAP_EN
        trapOn           = 1'b1;
        expMisLoad       = 32'h0000_0000;
        expAfterMisStore = 32'hABCD_0304;
`else
        trapOn           = 1'b0;
        expMisLoad       = 32'hDEAD_80EF;
        expAfterMisStore = 32'hCAFE_F00D;
`endif

        rst_n = 1'b0;
        driveRequest(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_rd", 32'(rd_o), 32'd0);
        checkOutput("rst_regwrite", 32'(regWrite_o), 32'd0);
        checkOutput("rst_misalign", 32'(misalign_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        storeOp("sw_10", 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
        checkOutput("sw_regwrite", 32'(regWrite_o), 32'd1);
        loadCheck("lw_10", 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
        checkOutput("lw_rd", 32'(rd_o), 32'd7);

        storeOp("sb_11", 3'b000, 32'h11, 32'h0000_0080, 1'b0);
        loadCheck("lb_11", 3'b000, 32'h11, 32'hFFFF_FF80, 1'b0);
        loadCheck("lbu_11", 3'b100, 32'h11, 32'h0000_0080, 1'b0);
        loadCheck("lw_after_sb", 3'b010, 32'h10, 32'hDEAD_80EF, 1'b0);
        loadCheck("lh_12", 3'b001, 32'h12, 32'hFFFF_DEAD, 1'b0);
        loadCheck("lhu_12", 3'b101, 32'h12, 32'h0000_DEAD, 1'b0);
        loadCheck("lw_wrap", 3'b010, 32'h0000_1010, 32'hDEAD_80EF, 1'b0);
        loadCheck("l_f3_111", 3'b111, 32'h10, 32'hDEAD_80EF, 1'b0);

        applyStimulus(1'b0, 1'b0, 3'b010, 32'h1234, 32'h0, 5'd5, 1'b1, cyc, stl);
        checkOutput("alu_lat", 32'(cyc), 32'd1);
        checkOutput("alu_result", result, 32'h1234);
        checkOutput("alu_rd", 32'(rd_o), 32'd5);
        checkOutput("alu_regwrite", 32'(regWrite_o), 32'd1);
        checkOutput("alu_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("idle_valid", 32'(valid_o), 32'd0);
        checkOutput("idle_regwrite", 32'(regWrite_o), 32'd0);
        checkOutput("idle_result_hold", result, 32'h1234);
        checkOutput("idle_rd_hold", 32'(rd_o), 32'd5);

        // Load with valid_i toggling during WAIT, then a held request taken on the valid_o cycle.
        @(negedge clk);
        driveRequest(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd7, 1'b1);
        @(posedge clk);
        #1;
        stl = 0;
        for (int c = 1; c <= LAT; c++) begin
            stl += int'(stall_o);
            if (c == LAT) driveRequest(1'b0, 1'b0, 3'b010, 32'h77, 32'h0, 5'd9, 1'b1);
            else if (c == 2) valid_i = 1'b0;
            else driveRequest(1'b0, 1'b1, 3'b010, 32'h10, 32'h99, 5'd1, 1'b0);
            @(posedge clk);
            #1;
        end
        checkOutput("hold_stall_cycles", 32'(stl), 32'(LAT));
        checkOutput("hold_load_valid", 32'(valid_o), 32'd1);
        checkOutput("hold_load_result", result, 32'hDEAD_80EF);
        checkOutput("hold_load_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        checkOutput("held_valid", 32'(valid_o), 32'd1);
        checkOutput("held_result", result, 32'h77);
        checkOutput("held_rd", 32'(rd_o), 32'd9);
        loadCheck("lw_ignored_store", 3'b010, 32'h10, 32'hDEAD_80EF, 1'b0);

        // Reset in the middle of a pending store cancels it.
        storeOp("sw_20", 3'b010, 32'h20, 32'h1122_3344, 1'b0);
        @(negedge clk);
        driveRequest(1'b0, 1'b1, 3'b010, 32'h20, 32'h55, 5'd3, 1'b1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_stall", 32'(stall_o), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(valid_o), 32'd0);
        checkOutput("mid_rst_stall", 32'(stall_o), 32'd0);
        checkOutput("mid_rst_result", result, 32'd0);
        checkOutput("mid_rst_rd", 32'(rd_o), 32'd0);
        checkOutput("mid_rst_regwrite", 32'(regWrite_o), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        loadCheck("lw_20_after_rst", 3'b010, 32'h20, 32'h1122_3344, 1'b0);

        storeOp("sw_24", 3'b010, 32'h24, 32'h0102_0304, 1'b0);
        storeOp("sh_26", 3'b001, 32'h26, 32'h0000_ABCD, 1'b0);
        loadCheck("lw_24", 3'b010, 32'h24, 32'hABCD_0304, 1'b0);

        loadCheck("lw_13_misalign", 3'b010, 32'h13, expMisLoad, trapOn);
        storeOp("sw_25_misalign", 3'b010, 32'h25, 32'hCAFE_F00D, trapOn);
        loadCheck("lw_24_after_mis", 3'b010, 32'h24, expAfterMisStore, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
